// File: rtl/midi_note_tracker.sv
// MIDI note tracker: parses a MIDI byte stream with running status and keeps
// a 4-deep last-note-priority stack. It drives the note, velocity, gate and a
// retrigger pulse for a monophonic voice.
module midi_note_tracker #(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] F_in,
  output logic       key_on,
  output logic [6:0] velocity,
  output logic       retrig
);

  localparam logic [3:0] CHAN = 4'(CHANNEL);
  localparam int unsigned DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] run_status, run_status_nx;
  logic [6:0] d1, d1_nx;

  logic       msg_done;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;

  logic       chan_ok;
  logic       is_press;
  logic       is_release;
  logic       is_all_off;

  // Stack: index 0 is the oldest entry, index count-1 is the top.
  logic [6:0] stk_note [DEPTH];
  logic [6:0] stk_vel  [DEPTH];
  logic [2:0] count;

  logic [6:0] cmp_note [DEPTH];
  logic [6:0] cmp_vel  [DEPTH];
  logic [2:0] cmp_cnt;
  logic       hit;
  logic [1:0] hit_idx;

  logic [6:0] nx_note [DEPTH];
  logic [6:0] nx_vel  [DEPTH];
  logic [2:0] nx_cnt;
  logic [1:0] old_top;
  logic [1:0] new_top;
  logic       retrig_nx;

  // Parser register update.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      run_status <= '0;
      d1         <= '0;
    end else begin
      state      <= state_nx;
      run_status <= run_status_nx;
      d1         <= d1_nx;
    end
  end

  // Parser next state and message-completion detection.
  always_comb begin
    state_nx      = state;
    run_status_nx = run_status;
    d1_nx         = d1;
    msg_done      = 1'b0;
    msg_d1        = d1;
    msg_d2        = rx_data[6:0];
    if (rx_valid) begin
      if (rx_data[7:3] == 5'b11111) begin
        // Realtime bytes pass through without touching the parser.
        state_nx = state;
      end else if (rx_data[7:4] == 4'hF) begin
        run_status_nx = '0;
        state_nx      = IDLE;
      end else if (rx_data[7]) begin
        run_status_nx = rx_data;
        state_nx      = WAIT_D1;
      end else begin
        case (state)
          WAIT_D1: begin
            if (run_status[7:5] == 3'b110) begin
              // Program change / channel pressure carry a single data byte.
              msg_done = 1'b1;
              msg_d1   = rx_data[6:0];
              msg_d2   = '0;
            end else begin
              d1_nx    = rx_data[6:0];
              state_nx = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_done = 1'b1;
            state_nx = WAIT_D1;
          end
          default: begin
            state_nx = IDLE;
          end
        endcase
      end
    end
  end

  // Message decode for the events the stack cares about.
  always_comb begin
    chan_ok    = OMNI || (run_status[3:0] == CHAN);
    is_press   = 1'b0;
    is_release = 1'b0;
    is_all_off = 1'b0;
    if (msg_done && chan_ok) begin
      case (run_status[7:4])
        4'h9: begin
          is_press   = (msg_d2 != 7'd0);
          is_release = (msg_d2 == 7'd0);
        end
        4'h8: is_release = 1'b1;
        4'hB: is_all_off = (msg_d1 == 7'd123) || (msg_d1 == 7'd120);
        default: ;
      endcase
    end
  end

  // Stack next state: locate the note, compact it out, then push if pressed.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((3'(i) < count) && (stk_note[i] == msg_d1)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      cmp_note[i] = stk_note[i];
      cmp_vel[i]  = stk_vel[i];
    end
    cmp_cnt = count;
    if (hit) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (2'(i) >= hit_idx) begin
          cmp_note[i] = stk_note[i+1];
          cmp_vel[i]  = stk_vel[i+1];
        end
      end
      cmp_cnt = count - 3'd1;
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      nx_note[i] = stk_note[i];
      nx_vel[i]  = stk_vel[i];
    end
    nx_cnt = count;

    if (is_all_off) begin
      nx_cnt = '0;
    end else if (is_press) begin
      if (cmp_cnt == 3'd4) begin
        // Full stack: the oldest entry falls off the bottom.
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          nx_note[i] = cmp_note[i+1];
          nx_vel[i]  = cmp_vel[i+1];
        end
        nx_note[DEPTH-1] = msg_d1;
        nx_vel[DEPTH-1]  = msg_d2;
        nx_cnt           = 3'd4;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          nx_note[i] = cmp_note[i];
          nx_vel[i]  = cmp_vel[i];
        end
        nx_note[cmp_cnt[1:0]] = msg_d1;
        nx_vel[cmp_cnt[1:0]]  = msg_d2;
        nx_cnt                = cmp_cnt + 3'd1;
      end
    end else if (is_release && hit) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        nx_note[i] = cmp_note[i];
        nx_vel[i]  = cmp_vel[i];
      end
      nx_cnt = cmp_cnt;
    end

    old_top = 2'(count - 3'd1);
    new_top = 2'(nx_cnt - 3'd1);

    // Every press leaves the pressed note on top, so it always retriggers;
    // a release retriggers only when it uncovers a different top note.
    retrig_nx = is_press ||
                (is_release && hit && (nx_cnt != 3'd0) &&
                 (nx_note[new_top] != stk_note[old_top]));
  end

  // Stack storage; contents are meaningless while count is zero.
  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      stk_note[i] <= nx_note[i];
      stk_vel[i]  <= nx_vel[i];
    end
  end

  // Count and voice outputs; pitch and velocity hold when the stack empties.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count    <= '0;
      key_on   <= 1'b0;
      retrig   <= 1'b0;
      F_in     <= '0;
      velocity <= '0;
    end else begin
      count  <= nx_cnt;
      key_on <= (nx_cnt != 3'd0);
      retrig <= retrig_nx;
      if (nx_cnt != 3'd0) begin
        F_in     <= {1'b0, nx_note[new_top]};
        velocity <= nx_vel[new_top];
      end
    end
  end

endmodule

// File: tb/tb_midi_note_tracker.sv
// Directed bench for midi_note_tracker with hand-computed expected outputs.
module tb_midi_note_tracker;

  logic       Clk;
  logic       Reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] F_in;
  logic       key_on;
  logic [6:0] velocity;
  logic       retrig;

  int n_chk;
  int n_fail;

  midi_note_tracker #(.CHANNEL(0), .OMNI(1'b0)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .F_in     (F_in),
    .key_on   (key_on),
    .velocity (velocity),
    .retrig   (retrig)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] f, input logic [6:0] v,
                           input logic k, input logic r);
    chk({tag, ".F_in"}, F_in, f);
    chk({tag, ".velocity"}, {1'b0, velocity}, {1'b0, v});
    chk({tag, ".key_on"}, {7'd0, key_on}, {7'd0, k});
    chk({tag, ".retrig"}, {7'd0, retrig}, {7'd0, r});
  endtask

  // One byte per call; outputs are sampled 1 time unit after the capturing edge.
  task automatic send(input logic [7:0] b);
    @(negedge Clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge Clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge Clk);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    Reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check_out("reset", 8'h00, 7'h00, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;

    // Basic note-on.
    send(8'h90); send(8'h3C); send(8'h64);
    check_out("on_3c", 8'h3C, 7'h64, 1'b1, 1'b1);
    idle();
    chk("retrig_one_cycle", {7'd0, retrig}, 8'h00);

    // Running-status press, then note-off back to the earlier note.
    send(8'h40); send(8'h50);
    check_out("rs_on_40", 8'h40, 7'h50, 1'b1, 1'b1);
    send(8'h80); send(8'h40); send(8'h00);
    check_out("off_40", 8'h3C, 7'h64, 1'b1, 1'b1);

    // Velocity-0 note-on empties the stack; pitch holds, no retrig.
    send(8'h90); send(8'h3C); send(8'h00);
    check_out("empty", 8'h3C, 7'h64, 1'b0, 1'b0);

    // Realtime bytes interleaved.
    send(8'h90); send(8'hFE); send(8'h3C); send(8'hF8); send(8'h7F);
    check_out("realtime", 8'h3C, 7'h7F, 1'b1, 1'b1);

    // Overflow: 3C then 30 drop out as 31..34 fill the stack.
    send(8'h30); send(8'h40);
    check_out("push_30", 8'h30, 7'h40, 1'b1, 1'b1);
    send(8'h31); send(8'h41);
    send(8'h32); send(8'h42);
    send(8'h33); send(8'h43);
    send(8'h34); send(8'h44);
    check_out("push_34", 8'h34, 7'h44, 1'b1, 1'b1);
    send(8'h34); send(8'h00);
    check_out("rel_34", 8'h33, 7'h43, 1'b1, 1'b1);
    send(8'h33); send(8'h00);
    check_out("rel_33", 8'h32, 7'h42, 1'b1, 1'b1);
    send(8'h32); send(8'h00);
    check_out("rel_32", 8'h31, 7'h41, 1'b1, 1'b1);
    send(8'h31); send(8'h00);
    check_out("rel_31_empty", 8'h31, 7'h41, 1'b0, 1'b0);

    // Re-press of top and of a buried note.
    send(8'h3C); send(8'h10);
    check_out("press_3c", 8'h3C, 7'h10, 1'b1, 1'b1);
    send(8'h3C); send(8'h20);
    check_out("repress_top", 8'h3C, 7'h20, 1'b1, 1'b1);
    send(8'h3D); send(8'h30);
    check_out("press_3d", 8'h3D, 7'h30, 1'b1, 1'b1);
    send(8'h3C); send(8'h40);
    check_out("repress_buried", 8'h3C, 7'h40, 1'b1, 1'b1);
    send(8'h3C); send(8'h00);
    check_out("rel_3c_top", 8'h3D, 7'h30, 1'b1, 1'b1);
    send(8'h3E); send(8'h50);
    send(8'h3D); send(8'h00);
    check_out("rel_non_top", 8'h3E, 7'h50, 1'b1, 1'b0);
    send(8'h3F); send(8'h00);
    check_out("rel_absent", 8'h3E, 7'h50, 1'b1, 1'b0);

    // Channel filtering and all-notes-off.
    send(8'h91); send(8'h3C); send(8'h64);
    check_out("other_chan", 8'h3E, 7'h50, 1'b1, 1'b0);
    send(8'hB0); send(8'h7B); send(8'h00);
    check_out("cc123", 8'h3E, 7'h50, 1'b0, 1'b0);
    send(8'h90); send(8'h3C); send(8'h64);
    check_out("on_again", 8'h3C, 7'h64, 1'b1, 1'b1);
    send(8'hB0); send(8'h07); send(8'h10);
    check_out("cc7_ignored", 8'h3C, 7'h64, 1'b1, 1'b0);
    send(8'h78); send(8'h00);
    check_out("cc120", 8'h3C, 7'h64, 1'b0, 1'b0);

    // Note-off with nonzero velocity, then system-common clears running status.
    send(8'h90); send(8'h40); send(8'h10);
    send(8'h80); send(8'h40); send(8'h55);
    check_out("noteoff_vel", 8'h40, 7'h10, 1'b0, 1'b0);
    send(8'h90); send(8'h41); send(8'h22);
    check_out("on_41", 8'h41, 7'h22, 1'b1, 1'b1);
    send(8'hF0); send(8'h41); send(8'h00);
    check_out("sysex_no_rs", 8'h41, 7'h22, 1'b1, 1'b0);

    // Reset mid-message.
    send(8'h90); send(8'h3C);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    check_out("mid_reset", 8'h00, 7'h00, 1'b0, 1'b0);
    send(8'h64);
    check_out("post_reset_data", 8'h00, 7'h00, 1'b0, 1'b0);
    send(8'h3C); send(8'h64);
    check_out("post_reset_idle", 8'h00, 7'h00, 1'b0, 1'b0);
    send(8'h90); send(8'h3C); send(8'h64);
    check_out("post_reset_on", 8'h3C, 7'h64, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_note_tracker.md
MIDI_NOTE_TRACKER -- requirements
Module: midi_note_tracker

Interface
REQ-001 Parameter CHANNEL, default 0: MIDI channel (0-15) accepted for voice messages.
REQ-002 Parameter OMNI, default 0: 1 = accept voice messages on any channel and ignore CHANNEL.
REQ-003 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 rx_data  input  8  received MIDI byte from the UART.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid when high.
REQ-007 F_in  output  8  note number for the voice; bit 7 always 0.
REQ-008 key_on  output  1  high while at least one note is held.
REQ-009 velocity  output  7  velocity of the sounding note.
REQ-010 retrig  output  1  one-cycle pulse when the sounding note changes or a note starts from silence.

Function
REQ-011 Parser states are IDLE (no running status), WAIT_D1 and WAIT_D2; the block stores an 8-bit running status and a 7-bit first data byte.
REQ-012 Byte 0x80-0xEF in any state: load running status, go to WAIT_D1, and discard any partial message.
REQ-013 Byte 0xF0-0xF7 in any state: clear running status and go to IDLE.
REQ-014 Byte 0xF8-0xFF (realtime): ignore; state, running status and data byte are unchanged.
REQ-015 Data byte (bit 7 = 0) in IDLE: ignore.
REQ-016 Data byte in WAIT_D1:
- status class 0xC or 0xD: message complete; stay in WAIT_D1 (running status).
- otherwise: store the byte and go to WAIT_D2.
REQ-017 Data byte in WAIT_D2: message complete; return to WAIT_D1 with running status kept.
REQ-018 A completed message acts only if the channel matches (status[3:0] = CHANNEL, or OMNI = 1); all other messages are consumed silently.
REQ-019 Note-on (0x9n) with velocity > 0 is a press; note-on with velocity 0 is a release; note-off (0x8n) is a release, whatever its velocity.
REQ-020 Control change 0xBn with controller 123 or 120 is all-notes-off: empty the stack.
REQ-021 Note stack: 4 entries of {note[6:0], vel[6:0]} plus a 3-bit count (0-4); "top" is the newest entry.
REQ-022 Press, note not in stack: push it to top; if count = 4, drop the oldest entry and keep count = 4.
REQ-023 Press, note already in stack: remove that entry, compact, then push it to top with the new velocity; count is unchanged.
REQ-024 Release, note in stack: remove the entry and compact, keeping order; count decrements.
REQ-025 Release, note absent: no effect.
REQ-026 The stack and all outputs update on the same edge that samples the completing byte, so the result is visible one cycle after that rx_valid.
REQ-027 key_on = (count != 0), registered.
REQ-028 When count != 0: F_in = {1'b0, top.note} and velocity = top.vel.
REQ-029 When count = 0: F_in and velocity hold their last values, so the release tail keeps its pitch.
REQ-030 retrig pulses for exactly one cycle, coincident with the output update, when:
- count goes from 0 to nonzero, or
- top note changes while count stays nonzero, or
- the same note is re-pressed while it is top.
REQ-031 retrig stays low on releases that empty the stack.
REQ-032 At most one byte is processed per cycle; rx_valid held high for consecutive cycles means consecutive bytes.

Reset
REQ-033 While Reset = 0 at a rising edge:
- state = IDLE, running status = 0, count = 0;
- F_in = 0, velocity = 0, key_on = 0, retrig = 0.
REQ-034 Reset asserted mid-message discards the partial message; the first data byte after reset is ignored until a status byte arrives.
REQ-035 Stack entry contents are don't-care while count = 0; no output may depend on them.

Verification
REQ-036 Bytes 90 3C 64 -> one cycle after the last byte: F_in = 0x3C, velocity = 0x64, key_on = 1, retrig pulses once.
REQ-037 Then bytes 40 50 (running status), then 80 40 00 -> F_in = 0x40 with retrig, then F_in = 0x3C with retrig and key_on still 1.
REQ-038 Then 90 3C 00 -> key_on = 0, F_in holds 0x3C, no retrig.
REQ-039 Send 90 3C 7F, then FE, then F8 interleaved between data bytes -> same result as with no realtime bytes; presses of notes 30/31/32/33/34 -> count = 4 and note 30 dropped; release 34 -> F_in = 0x33.
REQ-040 With CHANNEL = 0: 91 3C 64 -> no change. 90 3C 64, then B0 7B 00 -> key_on = 0. Send 90 3C, pull Reset low for one cycle, then send 64 -> all outputs 0 and 64 ignored.
